// File: rtl/fft_pkg.sv
// Shared constants, FSM encoding and address types for the radix-2 DIT FFT sequencer.
package fft_pkg;

  localparam int unsigned N_LOG2_DEF = 6;
  localparam int unsigned RD_LAT_DEF = 1;
  localparam int unsigned BF_LAT_DEF = 3;

  // Cycles from a read strobe to the matching write-back strobe.
  function automatic int unsigned drain_len(input int unsigned rd_lat, input int unsigned bf_lat);
    return rd_lat + bf_lat;
  endfunction

  localparam int unsigned L_DEF = drain_len(RD_LAT_DEF, BF_LAT_DEF);

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t DRAIN = 2'd2;
  localparam state_t DONE  = 2'd3;

  typedef logic [N_LOG2_DEF-1:0] addr_t;
  typedef logic [N_LOG2_DEF-2:0] tw_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational (stage, butterfly) -> (xa, xb, twiddle index) map for an in-place radix-2 DIT FFT.
module fft_addr_gen import fft_pkg::*; #(
  parameter int unsigned N_LOG2 = N_LOG2_DEF
) (
  input  logic [N_LOG2-1:0] s,
  input  logic [N_LOG2-2:0] j,
  output logic [N_LOG2-1:0] addr_a,
  output logic [N_LOG2-1:0] addr_b,
  output logic [N_LOG2-2:0] tw
);

  typedef logic [N_LOG2-1:0] a_t;
  typedef logic [N_LOG2-2:0] k_t;
  localparam a_t TOP = a_t'(N_LOG2 - 1);

  a_t jx, span, pos, grp;

  always_comb begin
    jx     = {1'b0, j};
    span   = a_t'(1) << s;
    pos    = jx & (span - 1'b1);
    grp    = jx >> s;
    addr_a = (grp << (s + 1'b1)) | pos;
    addr_b = addr_a + span;
    // pos < 2^s, so shifting by N_LOG2-1-s always fits the twiddle index width.
    tw     = k_t'(pos << (TOP - s));
  end

endmodule

// File: rtl/fft_sched.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT.
// Define FFT_SCHED_INV_EN to add the inv input and tw_conj output for inverse transforms.
module fft_sched import fft_pkg::*; #(
  parameter int unsigned N_LOG2 = N_LOG2_DEF,
  parameter int unsigned RD_LAT = RD_LAT_DEF,
  parameter int unsigned BF_LAT = BF_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef FFT_SCHED_INV_EN
  input  logic              inv,
  output logic              tw_conj,
`endif
  output logic              busy,
  output logic              done,
  output logic [N_LOG2-1:0] stage,
  output logic              rd_en,
  output logic [N_LOG2-1:0] rd_addr_a,
  output logic [N_LOG2-1:0] rd_addr_b,
  output logic [N_LOG2-2:0] tw_addr,
  output logic              bf_en,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr_a,
  output logic [N_LOG2-1:0] wr_addr_b
);

  localparam int unsigned L  = drain_len(RD_LAT, BF_LAT);
  localparam int unsigned DW = $clog2(L + 1);

  typedef logic [N_LOG2-1:0] stage_t;
  typedef logic [N_LOG2-2:0] j_t;
  typedef logic [DW-1:0]     dcnt_t;

  localparam stage_t S_LAST = stage_t'(N_LOG2 - 1);
  localparam j_t     J_LAST = '1;
  localparam dcnt_t  D_LAST = dcnt_t'(L - 1);

  state_t state_q, state_d;
  stage_t s_q, s_d;
  j_t     j_q, j_d;
  dcnt_t  dcnt_q, dcnt_d;
  logic   issue;

  logic [N_LOG2-1:0] ga, gb;
  logic [N_LOG2-2:0] gt;

  logic [RD_LAT-1:0] bf_sr;
  logic              wen_sr [L];
  logic [N_LOG2-1:0] wa_sr  [L];
  logic [N_LOG2-1:0] wb_sr  [L];

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    dcnt_d  = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          s_d     = '0;
          j_d     = '0;
        end
      end
      RUN: begin
        if (j_q == J_LAST) state_d = DRAIN;
        else               j_d     = j_q + 1'b1;
      end
      DRAIN: begin
        if (dcnt_q == D_LAST) begin
          if (s_q == S_LAST) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            s_d     = s_q + 1'b1;
            j_d     = '0;
          end
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the FSM state.
  assign issue = (state_d == RUN);

  fft_addr_gen #(
    .N_LOG2 (N_LOG2)
  ) u_addr_gen (
    .s      (s_d),
    .j      (j_d),
    .addr_a (ga),
    .addr_b (gb),
    .tw     (gt)
  );

`ifdef FFT_SCHED_INV_EN
  logic inv_q, inv_d;
  assign inv_d = (state_q == IDLE && start) ? inv : inv_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      s_q       <= '0;
      j_q       <= '0;
      dcnt_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
      bf_sr     <= '0;
      for (int i = 0; i < L; i++) begin
        wen_sr[i] <= 1'b0;
        wa_sr[i]  <= '0;
        wb_sr[i]  <= '0;
      end
`ifdef FFT_SCHED_INV_EN
      inv_q     <= 1'b0;
      tw_conj   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      j_q     <= j_d;
      dcnt_q  <= dcnt_d;
      busy    <= (state_d == RUN) || (state_d == DRAIN);
      done    <= (state_d == DONE);
      rd_en   <= issue;
      if (issue) begin
        rd_addr_a <= ga;
        rd_addr_b <= gb;
        tw_addr   <= gt;
      end
      bf_sr[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) bf_sr[i] <= bf_sr[i-1];
      wen_sr[0] <= rd_en;
      wa_sr[0]  <= rd_addr_a;
      wb_sr[0]  <= rd_addr_b;
      for (int i = 1; i < L; i++) begin
        wen_sr[i] <= wen_sr[i-1];
        wa_sr[i]  <= wa_sr[i-1];
        wb_sr[i]  <= wb_sr[i-1];
      end
`ifdef FFT_SCHED_INV_EN
      inv_q <= inv_d;
      if (issue) tw_conj <= inv_d;
`endif
    end
  end

  assign stage     = s_q;
  assign bf_en     = bf_sr[RD_LAT-1];
  assign wr_en     = wen_sr[L-1];
  assign wr_addr_a = wa_sr[L-1];
  assign wr_addr_b = wb_sr[L-1];

endmodule

// File: tb/tb_fft_sched.sv
// Random start/inv/reset stimulus on an 8-point and a 64-point sequencer, checked cycle by cycle
// against a timeline model of stage periods and butterfly pairings.
module tb_fft_sched;
  import fft_pkg::*;

  typedef struct {
    int busy, done, stage, rd_en, ra, rb, tw, bf_en, wr_en, wa, wb, conj;
  } obs_t;

  logic clk = 1'b0;
  logic rst, start, inv;
  always #5 clk = ~clk;

  // 8-point instance
  logic       busy0, done0, rd_en0, bf_en0, wr_en0, conj0;
  logic [2:0] stage0, ra0, rb0, wa0, wb0;
  logic [1:0] tw0;
  // default-size instance
  logic  busy1, done1, rd_en1, bf_en1, wr_en1, conj1;
  addr_t stage1, ra1, rb1, wa1, wb1;
  tw_t   tw1;

  fft_sched #(.N_LOG2(3)) u_small (
    .clk(clk), .rst(rst), .start(start),
`ifdef FFT_SCHED_INV_EN
    .inv(inv), .tw_conj(conj0),
`endif
    .busy(busy0), .done(done0), .stage(stage0), .rd_en(rd_en0), .rd_addr_a(ra0),
    .rd_addr_b(rb0), .tw_addr(tw0), .bf_en(bf_en0), .wr_en(wr_en0), .wr_addr_a(wa0),
    .wr_addr_b(wb0)
  );

  fft_sched u_dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef FFT_SCHED_INV_EN
    .inv(inv), .tw_conj(conj1),
`endif
    .busy(busy1), .done(done1), .stage(stage1), .rd_en(rd_en1), .rd_addr_a(ra1),
    .rd_addr_b(rb1), .tw_addr(tw1), .bf_en(bf_en1), .wr_en(wr_en1), .wr_addr_a(wa1),
    .wr_addr_b(wb1)
  );

`ifndef FFT_SCHED_INV_EN
  assign conj0 = 1'b0;
  assign conj1 = 1'b0;
`endif

  obs_t obs [2];
  always_comb begin
    obs[0] = '{int'(busy0), int'(done0), int'(stage0), int'(rd_en0), int'(ra0), int'(rb0),
               int'(tw0), int'(bf_en0), int'(wr_en0), int'(wa0), int'(wb0), int'(conj0)};
    obs[1] = '{int'(busy1), int'(done1), int'(stage1), int'(rd_en1), int'(ra1), int'(rb1),
               int'(tw1), int'(bf_en1), int'(wr_en1), int'(wa1), int'(wb1), int'(conj1)};
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int nl  [2] = '{3, N_LOG2_DEF};
  int c0  [2] = '{0, 0};
  bit running [2] = '{0, 0};
  bit inv_lat [2] = '{0, 0};
  bit rst_chk [2] = '{0, 0};

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  // j-th butterfly of stage s pairs the j-th index with bit s clear against its partner
  // span above; the twiddle exponent is that index's offset scaled to W_N.
  function automatic void pair(input int n, input int s, input int j,
                               output int a, output int b, output int k);
    int cnt = 0;
    a = -1; b = -1; k = -1;
    for (int x = 0; x < (1 << n); x++) begin
      if (((x >> s) & 1) == 0) begin
        if (cnt == j) begin
          a = x;
          b = x + (1 << s);
          k = (x % (1 << s)) * ((1 << (n - 1)) / (1 << s));
        end
        cnt++;
      end
    end
  endfunction

  task automatic check_dut(input int id);
    int n, half, per, tot, t, s, r, a, b, k;
    string p;
    obs_t o;
    o    = obs[id];
    n    = nl[id];
    half = 1 << (n - 1);
    per  = half + L_DEF;
    tot  = n * per;
    t    = cyc - c0[id];
    p    = (id == 0) ? "n8" : "n64";
    if (rst_chk[id]) begin
      check_eq({p, ".rst_stage"}, o.stage, 0);
      check_eq({p, ".rst_ra"}, o.ra, 0);
      check_eq({p, ".rst_rb"}, o.rb, 0);
      check_eq({p, ".rst_tw"}, o.tw, 0);
      check_eq({p, ".rst_wa"}, o.wa, 0);
      check_eq({p, ".rst_conj"}, o.conj, 0);
    end
    check_eq({p, ".done"}, o.done, int'(running[id] && t == tot + 1));
    if (running[id] && t >= 1 && t <= tot) begin
      s = (t - 1) / per;
      r = (t - 1) % per;
      check_eq({p, ".busy"}, o.busy, 1);
      check_eq({p, ".stage"}, o.stage, s);
      check_eq({p, ".rd_en"}, o.rd_en, int'(r < half));
      check_eq({p, ".bf_en"}, o.bf_en, int'(r >= RD_LAT_DEF && r < half + RD_LAT_DEF));
      check_eq({p, ".wr_en"}, o.wr_en, int'(r >= L_DEF && r < half + L_DEF));
      if (r < half) begin
        pair(n, s, r, a, b, k);
        check_eq({p, ".rd_addr_a"}, o.ra, a);
        check_eq({p, ".rd_addr_b"}, o.rb, b);
        check_eq({p, ".tw_addr"}, o.tw, k);
`ifdef FFT_SCHED_INV_EN
        check_eq({p, ".tw_conj"}, o.conj, int'(inv_lat[id]));
`endif
      end
      if (r >= L_DEF && r < half + L_DEF) begin
        pair(n, s, r - L_DEF, a, b, k);
        check_eq({p, ".wr_addr_a"}, o.wa, a);
        check_eq({p, ".wr_addr_b"}, o.wb, b);
      end
    end else begin
      check_eq({p, ".busy_idle"}, o.busy, 0);
      check_eq({p, ".rd_en_idle"}, o.rd_en, 0);
      check_eq({p, ".bf_en_idle"}, o.bf_en, 0);
      check_eq({p, ".wr_en_idle"}, o.wr_en, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; inv = 1'b0;
    for (int it = 0; it < 4000; it++) begin
      if (it < 3) rst = 1'b1;
      else        rst = ($urandom_range(0, 499) == 0);
      start = ($urandom_range(0, 11) == 0);
      inv   = 1'($urandom_range(0, 1));
      @(posedge clk);
      for (int id = 0; id < 2; id++) begin
        int tot;
        tot = nl[id] * ((1 << (nl[id] - 1)) + L_DEF);
        if (rst) begin
          running[id] = 1'b0;
        end else if (start && !(running[id] && cyc <= c0[id] + tot + 1)) begin
          running[id] = 1'b1;
          c0[id]      = cyc;
          inv_lat[id] = inv;
        end
        rst_chk[id] = rst;
      end
      cyc++;
      @(negedge clk);
      check_dut(0);
      check_dut(1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_sched.md
Name: fft_sched

Overview:
- Sequencing controller for an in-place radix-2 DIT FFT built around the pipelined butterfly unit (3-cycle latency) and a dual-port sample RAM.
- On start it walks every stage and every butterfly of that stage. For each butterfly it issues RAM read addresses, the twiddle-ROM address and the butterfly enable, then writes the results back.
- Input samples sit in RAM in bit-reversed order; results come out in natural order.
- Sits between the OFDM symbol buffer and the butterfly/RAM/ROM datapath.

Parameters:
- N_LOG2, 6, log2 of FFT size N (64-point OFDM default).
- RD_LAT, 1, RAM and twiddle-ROM read latency in cycles (registered outputs).
- BF_LAT, 3, butterfly en-to-valid latency.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  start FFT; sampled only in IDLE.
- busy  out  1  high from first issue cycle through last write.
- done  out  1  one-cycle pulse after final write.
- stage  out  N_LOG2 bits (≥3)  current stage index.
- rd_en  out  1  RAM read strobe, both ports.
- rd_addr_a  out  N_LOG2  read address, xa.
- rd_addr_b  out  N_LOG2  read address, xb.
- tw_addr  out  N_LOG2-1  twiddle ROM index k, giving W_N^k.
- bf_en  out  1  butterfly enable (rd_en delayed RD_LAT).
- wr_en  out  1  RAM write strobe, both ports.
- wr_addr_a  out  N_LOG2  write address, ya.
- wr_addr_b  out  N_LOG2  write address, yb.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters and delay lines cleared. A reset mid-transform aborts it with no further writes. RAM content is undefined.
- FSM states:
  - IDLE: start=1 → RUN, with s=0 and j=0.
  - RUN: issue one butterfly per cycle with j=0..N/2-1. After j=N/2-1 → DRAIN.
  - DRAIN: wait L=RD_LAT+BF_LAT cycles. Then, if s<N_LOG2-1, increment s, clear j and go to RUN; otherwise → DONE.
  - DONE: done=1 for one cycle, busy=0, then → IDLE.
- start while not in IDLE is ignored.
- Addressing for stage s, butterfly j:
  - span = 2^s, pos = j mod span, grp = j >> s.
  - rd_addr_a = grp·2^(s+1) + pos.
  - rd_addr_b = rd_addr_a + span.
  - tw_addr = pos << (N_LOG2-1-s).
  - All values are registered outputs, valid with rd_en=1 in RUN.
- Pipeline alignment:
  - bf_en is rd_en delayed RD_LAT cycles.
  - wr_en, wr_addr_a and wr_addr_b are rd_en, rd_addr_a and rd_addr_b delayed L cycles via a shift register. wr_en therefore coincides with butterfly valid.
- Hazard rule:
  - The first read of stage s+1 occurs exactly one cycle after the last write of stage s (RAM must be read-after-write safe across one edge).
  - No stage overlap.
- Timing:
  - Stage period is N/2+L cycles.
  - With start sampled in cycle 0: first rd_en at cycle 1, final wr_en at cycle N_LOG2·(N/2+L), done the cycle after.
  - For defaults: final write at cycle 216, done at 217.
- busy rises the cycle rd_en first rises and falls the cycle done rises.

Optional Feature:
- Macro FFT_SCHED_INV_EN.
- Defined:
  - Adds input `inv` (1), latched in IDLE on start.
  - Adds output `tw_conj` (1) = latched inv, driven aligned with tw_addr (same cycle, same delay). Downstream twiddle logic negates w_imag, giving an IFFT.
  - tw_conj resets to 0.
- Undefined: neither port exists; the block performs forward FFT only.

Decomposition:
- Package fft_pkg holds:
  - N_LOG2, RD_LAT and BF_LAT defaults.
  - The derived L constant.
  - The FSM state enum (IDLE, RUN, DRAIN, DONE).
  - The addr_t typedef (N_LOG2 bits) and tw_t typedef (N_LOG2-1 bits).
- One sub-module, fft_addr_gen: combinational mapping (s, j) → (addr_a, addr_b, tw). It is reusable by the bit-reverse loader.
- FSM, counters and the write delay line stay in fft_sched.

Test Plan:
- Small-size address sequence. N_LOG2=3, pulse start → issues the following (a,b,tw) per stage, then done at cycle 25:
  - stage 0: (0,1,0),(2,3,0),(4,5,0),(6,7,0)
  - stage 1: (0,2,0),(1,3,2),(4,6,0),(5,7,2)
  - stage 2: (0,4,0),(1,5,1),(2,6,2),(3,7,3)
- Alignment. N_LOG2=3:
  - Each wr_en is 4 cycles after its rd_en, with identical addresses.
  - bf_en is 1 cycle after rd_en.
  - Gap between stage 0's last wr_en (cycle 8) and stage 1's first rd_en (cycle 9) is 1 cycle.
- Full transform. Defaults, bit-reversed impulse at index 0, with the butterfly and RAM model → all 64 outputs equal to the input amplitude; busy is high for 216 cycles; single done pulse.
- Start while busy. Pulse start again at cycles 10 and 100 → no change in the address sequence, exactly one done.
- Reset mid-run. Assert rst at cycle 50 for 1 cycle → all outputs 0 at cycle 51; no wr_en afterwards; a new start then completes normally.
- Inverse (FFT_SCHED_INV_EN defined). start with inv=1 → tw_conj=1 on every issue cycle. A subsequent start with inv=0 → tw_conj=0 throughout.
